riscv_fetch_fifo_ctrl: RTL
==========================

// Module: riscv_fetch_fifo_ctrl
// PURPOSE
// Instruction prefetcher sitting directly upstream of the IF stage; drives the instruction memory port.
// Issues sequential word fetches and tracks outstanding transactions.
// Buffers returned words in a small FIFO and hands them to IF as (rdata, addr) pairs.
// Discards stale responses after a branch. Pure control/buffering; no decoding.
// PARAMETERS
// DEPTH    2  FIFO entries (>=2)
// MAX_OUT  2  max outstanding granted-but-not-returned requests (1..DEPTH)
// PORTS
// clk              in   1   clock
// rst_n            in   1   async active-low reset
// req_i            in   1   fetch enable from controller; 0 = stop issuing new requests
// branch_i         in   1   redirect: flush and restart at addr_i
// addr_i           in   32  branch target; bit0 ignored
// ready_i          in   1   IF consumes head entry this cycle
// valid_o          out  1   head entry valid
// rdata_o          out  32  head instruction word
// addr_o           out  32  PC of head entry
// instr_req_o      out  1   memory request
// instr_addr_o     out  32  word-aligned request address
// instr_gnt_i      in   1   memory grant
// instr_rvalid_i   in   1   response valid (in-order)
// instr_rdata_i    in   32  response data
// busy_o           out  1   request pending or responses outstanding
// BEHAVIOUR
// - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values: valid_o=0, rdata_o=0, addr_o=0, instr_req_o=0, instr_addr_o=0, busy_o=0; FIFO empty; counters 0.
// - FSM IDLE/RUN:
//   - IDLE->RUN on branch_i. RUN->IDLE when req_i=0 and no outstanding requests.
//   - branch_i in any state restarts at addr_i.
// - Issue rule: instr_req_o=1 in RUN when req_i & (out_cnt<MAX_OUT) & (fifo_cnt+out_cnt<DEPTH).
// - Request hold: an ungranted request holds instr_addr_o stable. Exception: branch_i replaces it with {addr_i[31:2],2'b00} in the same cycle.
// - On instr_req_o & instr_gnt_i: out_cnt++ and instr_addr_o += 4.
// - On accepted rvalid: out_cnt--. Simultaneous grant and rvalid leaves out_cnt unchanged.
// - Branch: FIFO cleared and valid_o=0 in the branch cycle.
//   - disc_cnt := out_cnt (plus 1 if a grant occurs in the same cycle). The next disc_cnt rvalids are dropped, not written.
//   - next_pc := addr_i & ~1.
// - Odd-halfword target: for the first entry after a branch with addr_i[1]=1, rdata_o = {16'h0, word[31:16]}.
//   - That entry's addr_o = target; following entries are word-aligned.
// - addr_o of each entry = next_pc at write; next_pc advances to the next word boundary.
// - Fall-through: if the FIFO is empty and a non-discarded rvalid arrives, valid_o=1 in the same cycle (0-cycle latency).
//   - If ready_i is also 1, the word is not stored.
// - Pop when valid_o & ready_i & ~branch_i. Push and pop in the same cycle keep fifo_cnt unchanged.
// - Overflow cannot occur by the issue rule; the bench asserts it.
// - busy_o = instr_req_o | (out_cnt != 0).
// - Wrap-around: instr_addr_o and next_pc wrap modulo 2^32.
// CONFIGURATION
// DIFT_FETCH_TAG_EN defined:
//   - adds port instr_rtag_i (in, 4) and rtag_o (out, 4);
//   - tag stored per FIFO entry alongside data; reset 0; discarded with its data.
// Not defined: ports absent, no tag storage. All other behaviour identical.
// TESTING
// 1. Reset, branch_i to 0x1000, gnt=1, rvalid 1 cycle after gnt -> addr_o 0x1000, 0x1004, 0x1008 in order; instr_addr_o never exceeds 2 ahead of consumption.
// 2. ready_i=0 with DEPTH=2 -> instr_req_o drops after 2 issued; resumes 1 cycle after first pop.
// 3. Two outstanding, branch_i to 0x2000 -> next 2 rvalids dropped; first valid_o has addr_o=0x2000.
// 4. Branch to 0x3002, word 0xAAAABBBB -> rdata_o=0x0000AAAA, addr_o=0x3002; next addr_o=0x3004.
// 5. gnt held 0 for 5 cycles -> instr_addr_o stable; branch_i in cycle 3 changes it to the new target.
// 6. Reset asserted mid-transfer with out_cnt=2 -> all outputs at reset values; later rvalids ignored until a branch.

Source files
------------

// File: rtl/riscv_fetch_fifo_ctrl_if.sv
// Instruction-memory port of the fetch prefetcher (request/grant, in-order response).
// With DIFT_FETCH_TAG_EN defined, responses also carry a 4-bit tag.
interface riscv_fetch_fifo_ctrl_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
`ifdef DIFT_FETCH_TAG_EN
    logic [3:0]  instr_rtag_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_rtag_i
    );
    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_rtag_i
    );
`else
    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i
    );
    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i
    );
`endif
endinterface

// File: rtl/riscv_fetch_fifo_ctrl.sv
// Sequential instruction prefetcher with a small response FIFO and branch flush.
// Optional feature: DIFT_FETCH_TAG_EN adds a per-entry 4-bit response tag (rtag_o).
module riscv_fetch_fifo_ctrl #(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_i,
    input  logic                           branch_i,
    input  logic [31:0]                    addr_i,
    input  logic                           ready_i,
    output logic                           valid_o,
    output logic [31:0]                    rdata_o,
    output logic [31:0]                    addr_o,
`ifdef DIFT_FETCH_TAG_EN
    output logic [3:0]                     rtag_o,
`endif
    output logic                           busy_o,
    riscv_fetch_fifo_ctrl_if.master        mem
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt, out_cnt, out_cnt_d, disc_cnt;
    logic [31:0]       req_addr, next_pc;

    logic [31:0]       data_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
`ifdef DIFT_FETCH_TAG_EN
    logic [3:0]        tag_mem  [DEPTH];
`endif

    logic        issue, gnt_fire, rsp_acc, rsp_drop, produce;
    logic        fifo_empty, fifo_pop, push;
    logic [31:0] rsp_word;
    logic        unused_addr_bit;

    assign unused_addr_bit = addr_i[0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counting in-flight requests together with buffered words keeps every response a home.
    assign issue = (state_q == RUN) && req_i && (out_cnt < MAX_OUT_C)
                 && (({1'b0, fifo_cnt} + {1'b0, out_cnt}) < DEPTH_C);

    assign mem.instr_req_o  = issue;
    assign mem.instr_addr_o = req_addr;
    assign busy_o           = issue || (out_cnt != '0);

    assign gnt_fire   = issue && mem.instr_gnt_i;
    assign rsp_acc    = mem.instr_rvalid_i && (out_cnt != '0);
    assign rsp_drop   = rsp_acc && (disc_cnt != '0);
    assign produce    = rsp_acc && !rsp_drop && !branch_i;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_pop   = !fifo_empty && ready_i && !branch_i;
    assign push       = produce && !(fifo_empty && ready_i);
    assign out_cnt_d  = out_cnt + CNT_W'(gnt_fire) - CNT_W'(rsp_acc);

    // A halfword-aligned branch target is the only way next_pc[1] gets set.
    assign rsp_word = next_pc[1] ? {16'h0000, mem.instr_rdata_i[31:16]} : mem.instr_rdata_i;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (branch_i) state_d = RUN;
            RUN:  if (!branch_i && !req_i && (out_cnt == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        rdata_o = '0;
        addr_o  = '0;
`ifdef DIFT_FETCH_TAG_EN
        rtag_o  = '0;
`endif
        if (!branch_i) begin
            if (!fifo_empty) begin
                valid_o = 1'b1;
                rdata_o = data_mem[rd_ptr];
                addr_o  = pc_mem[rd_ptr];
`ifdef DIFT_FETCH_TAG_EN
                rtag_o  = tag_mem[rd_ptr];
`endif
            end else if (produce) begin
                valid_o = 1'b1;
                rdata_o = rsp_word;
                addr_o  = next_pc;
`ifdef DIFT_FETCH_TAG_EN
                rtag_o  = mem.instr_rtag_i;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            disc_cnt <= '0;
            req_addr <= '0;
            next_pc  <= '0;
        end else begin
            state_q <= state_d;
            out_cnt <= out_cnt_d;

            if (branch_i) begin
                // In-flight requests after this cycle all belong to the old stream.
                disc_cnt <= out_cnt_d;
                req_addr <= {addr_i[31:2], 2'b00};
                next_pc  <= {addr_i[31:1], 1'b0};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (rsp_drop) disc_cnt <= disc_cnt - 1'b1;
                if (gnt_fire) req_addr <= req_addr + 32'd4;
                if (produce)  next_pc  <= {next_pc[31:2] + 30'd1, 2'b00};
                if (push)     wr_ptr   <= ptr_inc(wr_ptr);
                if (fifo_pop) rd_ptr   <= ptr_inc(rd_ptr);
                case ({push, fifo_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    // NOTE: the storage array is not reset; fifo_cnt gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= rsp_word;
            pc_mem[wr_ptr]   <= next_pc;
`ifdef DIFT_FETCH_TAG_EN
            tag_mem[wr_ptr]  <= mem.instr_rtag_i;
`endif
        end
    end

endmodule
